// File: rtl/pipe_add_sub.sv
`default_nettype none
//==============================================================================
// Module      : pipe_add_sub
// Description : Pipelined WIDTH-bit adder/subtractor, one chunk per stage, with
//               valid/ready streaming. Optional clamp on signed overflow when
//               SATURATE_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
module pipe_add_sub #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int c_CHUNK = WIDTH / STAGES;

    if (WIDTH % STAGES != 0) begin : g_width_chk
        $error("pipe_add_sub: WIDTH must be a multiple of STAGES");
    end
    if (STAGES < 1 || STAGES > WIDTH) begin : g_stages_chk
        $error("pipe_add_sub: STAGES must be in 1..WIDTH");
    end

    logic             w_adv;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_ovf;

    // Per-stage inputs: index 0 comes from the ports, index k from stage k-1 registers
    logic [WIDTH-1:0] w_a   [STAGES];
    logic [WIDTH-1:0] w_b   [STAGES];
    logic [WIDTH-1:0] w_sum [STAGES];
    logic             w_sub [STAGES];
    logic             w_cin [STAGES];
    logic             w_vld [STAGES];

    assign w_adv     = ~r_out_valid | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign carry_out = r_carry;
    assign overflow  = r_ovf;

    assign w_a[0]   = a;
    assign w_b[0]   = b;
    assign w_sum[0] = '0;
    assign w_sub[0] = sub;
    assign w_cin[0] = sub;
    assign w_vld[0] = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [c_CHUNK:0]   w_part;
        logic [WIDTH-1:0]   w_nsum;

        always_comb begin
            w_part = {1'b0, w_a[k][k*c_CHUNK +: c_CHUNK]}
                   + {1'b0, w_b[k][k*c_CHUNK +: c_CHUNK] ^ {c_CHUNK{w_sub[k]}}}
                   + {{c_CHUNK{1'b0}}, w_cin[k]};
            w_nsum = w_sum[k];
            w_nsum[k*c_CHUNK +: c_CHUNK] = w_part[c_CHUNK-1:0];
        end

        if (k < STAGES - 1) begin : g_mid
            logic             r_vld;
            logic             r_sub;
            logic             r_cy;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic [WIDTH-1:0] r_psum;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld  <= 1'b0;
                    r_sub  <= 1'b0;
                    r_cy   <= 1'b0;
                    r_a    <= '0;
                    r_b    <= '0;
                    r_psum <= '0;
                end else if (w_adv) begin
                    r_vld  <= w_vld[k];
                    r_sub  <= w_sub[k];
                    r_cy   <= w_part[c_CHUNK];
                    r_a    <= w_a[k];
                    r_b    <= w_b[k];
                    r_psum <= w_nsum;
                end
            end

            assign w_a[k+1]   = r_a;
            assign w_b[k+1]   = r_b;
            assign w_sum[k+1] = r_psum;
            assign w_sub[k+1] = r_sub;
            assign w_cin[k+1] = r_cy;
            assign w_vld[k+1] = r_vld;
        end else begin : g_last
            logic             w_ovf;
            logic [WIDTH-1:0] w_res;

            always_comb begin
                w_ovf = (w_a[k][WIDTH-1] ~^ (w_b[k][WIDTH-1] ^ w_sub[k]))
                      & (w_nsum[WIDTH-1] ^ w_a[k][WIDTH-1]);
                w_res = w_nsum;
`ifdef SATURATE_EN
                // Clamp toward the sign of A: only same-sign operands can overflow
                if (w_ovf) begin
                    w_res = w_a[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                            : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_out_valid <= 1'b0;
                    r_sum       <= '0;
                    r_carry     <= 1'b0;
                    r_ovf       <= 1'b0;
                end else if (w_adv) begin
                    r_out_valid <= w_vld[k];
                    r_sum       <= w_res;
                    r_carry     <= w_part[c_CHUNK];
                    r_ovf       <= w_ovf;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_add_sub.sv
`default_nettype none
//==============================================================================
// Module      : tb_pipe_add_sub
// Description : Self-checking bench for pipe_add_sub (WIDTH=8, STAGES=2) against
//               an arithmetic scoreboard model. Honours SATURATE_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_pipe_add_sub;

    localparam int c_WIDTH  = 8;
    localparam int c_STAGES = 2;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [c_WIDTH-1:0] a;
    logic [c_WIDTH-1:0] b;
    logic               sub;
    logic               out_valid;
    logic               out_ready;
    logic [c_WIDTH-1:0] sum;
    logic               carry_out;
    logic               overflow;

    pipe_add_sub #(.WIDTH(c_WIDTH), .STAGES(c_STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [c_WIDTH+1:0] exp;
        longint             tag;
    } op_t;

    op_t    q[$];
    longint advcnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Result {overflow, carry, sum} from integer arithmetic on the operands
    function automatic logic [c_WIDTH+1:0] model(input logic [c_WIDTH-1:0] x,
                                                  input logic [c_WIDTH-1:0] y,
                                                  input logic s);
        longint modv, ux, uy, full, sx, sy, r;
        logic [c_WIDTH-1:0] res;
        logic cy, ov;
        modv = longint'(1) << c_WIDTH;
        ux   = longint'(x);
        uy   = s ? (modv - 1 - longint'(y)) : longint'(y);
        full = ux + uy + longint'(s);
        res  = c_WIDTH'(full % modv);
        cy   = (full >= modv);
        sx   = x[c_WIDTH-1] ? ux - modv : ux;
        sy   = y[c_WIDTH-1] ? longint'(y) - modv : longint'(y);
        r    = s ? sx - sy : sx + sy;
        ov   = (r > (modv / 2 - 1)) || (r < -(modv / 2));
`ifdef SATURATE_EN
        if (ov) res = (sx < 0) ? c_WIDTH'(modv / 2) : c_WIDTH'(modv / 2 - 1);
`endif
        return {ov, cy, res};
    endfunction

    // Compare process: everything is stable at the falling edge
    logic               prev_hold = 1'b0;
    logic [c_WIDTH+1:0] prev_out;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            prev_hold = 1'b0;
        end else begin
            chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (prev_hold) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_fields", 64'({overflow, carry_out, sum}), 64'(prev_out));
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    chk("result", 64'({overflow, carry_out, sum}), 64'(q[0].exp));
                    chk("latency", 64'(advcnt - q[0].tag), 64'(c_STAGES));
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_out  = {overflow, carry_out, sum};
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back('{exp: model(a, b, sub), tag: advcnt});
            if (!out_valid || out_ready) advcnt++;
        end
    end

    // Present one op and hold it until accepted; returns stall cycles seen
    task automatic send(input logic [c_WIDTH-1:0] x, input logic [c_WIDTH-1:0] y,
                        input logic s, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        sub      = s;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) begin
                chk("send_timeout", 64'(waited), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int cyc = 0;
        while (q.size() != 0 && cyc < 40) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        @(negedge clk);
        chk(nm, 64'(q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int w;
    int wsum;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_fields", 64'({overflow, carry_out, sum}), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 64'(in_ready), 64'd1);

        // Pin the model to hand-computed results
        chk("model_ff_plus_01", 64'(model(8'hFF, 8'h01, 1'b0)), 64'({1'b0, 1'b1, 8'h00}));
        chk("model_05_minus_07", 64'(model(8'h05, 8'h07, 1'b1)), 64'({1'b0, 1'b0, 8'hFE}));
`ifdef SATURATE_EN
        chk("model_7f_plus_01", 64'(model(8'h7F, 8'h01, 1'b0)), 64'({1'b1, 1'b0, 8'h7F}));
        chk("model_80_minus_01", 64'(model(8'h80, 8'h01, 1'b1)), 64'({1'b1, 1'b1, 8'h80}));
`else
        chk("model_7f_plus_01", 64'(model(8'h7F, 8'h01, 1'b0)), 64'({1'b1, 1'b0, 8'h80}));
        chk("model_80_minus_01", 64'(model(8'h80, 8'h01, 1'b1)), 64'({1'b1, 1'b1, 8'h7F}));
`endif

        // Directed vectors
        send(8'hFF, 8'h01, 1'b0, w);
        idle(3);
        send(8'h05, 8'h07, 1'b1, w);
        idle(3);
        send(8'h7F, 8'h01, 1'b0, w);
        idle(3);
        send(8'h80, 8'h01, 1'b1, w);
        idle(3);

        // Back-to-back stream must never stall
        wsum = 0;
        for (int i = 0; i < 8; i++) begin
            send(c_WIDTH'(i), c_WIDTH'(i), 1'b0, w);
            wsum += w;
        end
        chk("b2b_no_stall", 64'(wsum), 64'd0);
        drain("b2b_drain");

        // Backpressure: three ops queued behind a stalled output
        out_ready = 1'b0;
        fork
            begin
                send(8'h11, 8'h22, 1'b0, w);
                send(8'h90, 8'h33, 1'b1, w);
                send(8'h44, 8'h44, 1'b0, w);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("stall_drain");

        // Reset with two ops in flight
        send(8'h01, 8'h02, 1'b0, w);
        send(8'h03, 8'h04, 1'b0, w);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_fields", 64'({overflow, carry_out, sum}), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
        send(8'h09, 8'h04, 1'b1, w);
        drain("post_reset_drain");

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            sub       = $urandom_range(0, 1);
            a         = ($urandom_range(0, 7) == 0) ? 8'h7F : c_WIDTH'($urandom);
            b         = ($urandom_range(0, 7) == 0) ? 8'h80 : c_WIDTH'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("random_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
